// File: rtl/prbs_checker_16_pkg.sv
// Shared definitions for the 16-bit PRBS generator/checker pair:
// state encoding, LFSR tap positions and the one-step predictor.
package prbs_checker_16_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic logic [15:0] prbs_next(input logic [15:0] x);
        return {x[14:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
    endfunction

endpackage

// File: rtl/prbs_next_16.sv
// Combinational one-step advance of the 16-bit LFSR state word.
module prbs_next_16
    import prbs_checker_16_pkg::*;
(
    input  logic [15:0] cur,
    output logic [15:0] nxt
);

    assign nxt = prbs_next(cur);

endmodule

// File: rtl/prbs_checker_16.sv
// PRBS-16 checker: searches for a run of correctly predicted words, then
// flywheels on its own prediction and counts mismatches while locked.
module prbs_checker_16
    import prbs_checker_16_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [3:0] LOCK_RUN   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_RUN = 4'(UNLOCK_CNT);

    state_t      state;
    logic [15:0] prev;
    logic        has_prev;
    logic [3:0]  run;

    logic [15:0] pred;
    logic        match;
    logic [3:0]  run_inc;

    prbs_next_16 u_next (
        .cur (prev),
        .nxt (pred)
    );

    assign match   = (in_data == pred);
    assign run_inc = run + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEARCH;
            prev      <= '0;
            has_prev  <= 1'b0;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            // Clear has priority over any increment made on the same edge.
            if (clear_cnt) begin
                err_count <= '0;
            end
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        prev     <= in_data;
                        has_prev <= 1'b1;
                        if (!has_prev) begin
                            run <= '0;
                        end else if (match && (in_data != 16'h0000)) begin
                            if (run_inc == LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            run  <= '0;
                            prev <= pred;
                        end else begin
                            err_pulse <= 1'b1;
                            if (!clear_cnt && (err_count != ERR_MAX)) begin
                                err_count <= err_count + 16'd1;
                            end
                            // On losing lock, resynchronise to the received word.
                            if (run_inc == UNLOCK_RUN) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                run      <= '0;
                                has_prev <= 1'b1;
                                prev     <= in_data;
                            end else begin
                                run  <= run_inc;
                                prev <= pred;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker_16.sv
// Directed bench for prbs_checker_16: scoreboarded main instance plus a
// second instance driven into err_count saturation.
module tb_prbs_checker_16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters).
    logic        reset_n   = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = 16'h0000;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    // Saturation instance: lock after one match, unlock after fifteen misses.
    logic        s_reset_n   = 1'b1;
    logic        s_in_valid  = 1'b0;
    logic [15:0] s_in_data   = 16'h0000;
    logic        s_clear_cnt = 1'b0;
    logic        s_locked;
    logic        s_err_pulse;
    logic [15:0] s_err_count;

    prbs_checker_16 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_checker_16 #(.LOCK_CNT(1), .UNLOCK_CNT(15)) dut_sat (
        .clk       (clk),
        .reset_n   (s_reset_n),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .clear_cnt (s_clear_cnt),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .err_count (s_err_count)
    );

    int checks = 0;
    int errors = 0;
    int sb_n   = 0;

    // Expected {locked, err_pulse, err_count} after each driven cycle.
    logic [17:0] exp_q[$];
    logic [17:0] exp_e;
    logic        issued   = 1'b0;
    logic        issued_d = 1'b0;

    logic [15:0] pv, ex, w;
    logic [15:0] seq [5];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] bad_word(input logic [15:0] e);
        return (e == 16'h8000) ? 16'h4000 : (e ^ 16'h8000);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Drive one cycle at the falling edge and queue what the DUT must show
    // one clock later.
    task automatic cyc(input logic v, input logic [15:0] d, input logic c,
                       input logic l, input logic p, input logic [15:0] n);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clear_cnt = c;
        issued    = 1'b1;
        exp_q.push_back({l, p, n});
    endtask

    task automatic idle(input int n, input logic l, input logic [15:0] cnt);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, l, 1'b0, cnt);
    endtask

    always @(posedge clk) issued_d <= issued;

    // Monitor: compares the DUT outputs for the cycle driven one clock earlier.
    always @(negedge clk) begin
        if (issued_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got empty queue want entry at #%0d", sb_n);
            end else begin
                exp_e = exp_q.pop_front();
                check($sformatf("locked#%0d", sb_n), 16'(locked), 16'(exp_e[17]));
                check($sformatf("err_pulse#%0d", sb_n), 16'(err_pulse), 16'(exp_e[16]));
                check($sformatf("err_count#%0d", sb_n), err_count, exp_e[15:0]);
            end
            sb_n++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seq[0] = 16'h1001; seq[1] = 16'h2003; seq[2] = 16'h4007;
        seq[3] = 16'h800E; seq[4] = 16'h001D;

        // Asynchronous reset without any clock edge.
        #1;
        reset_n   = 1'b0;
        s_reset_n = 1'b0;
        #2;
        check("rst_locked", 16'(locked), 16'h0);
        check("rst_err_pulse", 16'(err_pulse), 16'h0);
        check("rst_err_count", err_count, 16'h0000);
        check("rst_s_err_count", s_err_count, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        s_reset_n = 1'b1;

        fork
            begin : main_seq
                // Basic lock: first word loads, four matches lock.
                cyc(1, 16'h1001, 0, 0, 0, 0);
                cyc(1, 16'h2003, 0, 0, 0, 0);
                cyc(1, 16'h4007, 0, 0, 0, 0);
                cyc(1, 16'h800E, 0, 0, 0, 0);
                cyc(1, 16'h001D, 0, 1, 0, 0);
                // Single bad word (expected 003A), then 0074 matches; clear on the match.
                cyc(1, 16'h0000, 0, 1, 1, 1);
                cyc(1, 16'h0074, 1, 1, 0, 0);
                idle(1, 1, 0);
                // Three misses (expected 00E8,01D0,03A0) drop lock; resync prev=FFFF.
                cyc(1, 16'hFFFF, 0, 1, 1, 1);
                cyc(1, 16'hFFFF, 0, 1, 1, 2);
                cyc(1, 16'hFFFF, 0, 0, 1, 3);
                cyc(1, 16'hFFFE, 0, 0, 0, 3);
                cyc(1, 16'hFFFC, 0, 0, 0, 3);
                cyc(1, 16'hFFF8, 0, 0, 0, 3);
                cyc(1, 16'hFFF0, 0, 1, 0, 3);
                // Unlock via zeros (expected FFE0...), leaving prev=0000.
                cyc(1, 16'h0000, 0, 1, 1, 4);
                cyc(1, 16'h0000, 0, 1, 1, 5);
                cyc(1, 16'h0000, 0, 0, 1, 6);
                // next(0000)=0000 must never count as a match.
                for (int i = 0; i < 4; i++) cyc(1, 16'h0000, 0, 0, 0, 6);
                // Relock with 0..3 idle cycles between valid samples.
                for (int i = 0; i < 5; i++) begin
                    idle(i % 4, 0, 6);
                    cyc(1, seq[i], 0, (i == 4), 0, 6);
                end
                idle(2, 1, 6);
                // Mismatch, then reset mid-cycle while err_pulse is high.
                cyc(1, 16'h0000, 0, 1, 1, 7);
                @(negedge clk);
                in_valid = 1'b0;
                issued   = 1'b0;
                #1;
                reset_n = 1'b0;
                #1;
                check("midrst_locked", 16'(locked), 16'h0);
                check("midrst_err_pulse", 16'(err_pulse), 16'h0);
                check("midrst_err_count", err_count, 16'h0000);
                @(negedge clk);
                reset_n = 1'b1;
                for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, (i == 4), 0, 0);
                @(negedge clk);
                in_valid = 1'b0;
                issued   = 1'b0;
                repeat (2) @(negedge clk);
                check("sb_drained", 16'(exp_q.size()), 16'h0);
            end
            begin : sat_seq
                @(negedge clk);
                s_in_valid = 1'b1;
                s_in_data  = 16'h1001;
                pv         = 16'h1001;
                // 4368 rounds of relock + 15 misses = 65520 counted mismatches.
                for (int r = 0; r < 4368; r++) begin
                    @(negedge clk);
                    pv = lfsr_next(pv);
                    s_in_data = pv;
                    for (int k = 1; k <= 15; k++) begin
                        @(negedge clk);
                        ex = lfsr_next(pv);
                        w  = bad_word(ex);
                        s_in_data = w;
                        pv = (k == 15) ? w : ex;
                    end
                end
                @(negedge clk);
                pv = lfsr_next(pv);
                s_in_data = pv;
                for (int k = 1; k <= 14; k++) begin
                    @(negedge clk);
                    ex = lfsr_next(pv);
                    s_in_data = bad_word(ex);
                    pv = ex;
                end
                @(negedge clk);
                check("sat_fffe_count", s_err_count, 16'hFFFE);
                check("sat_fffe_locked", 16'(s_locked), 16'h1);
                ex = lfsr_next(pv);
                w  = bad_word(ex);
                s_in_data = w;
                pv = w;
                @(negedge clk);
                check("sat_ffff_count", s_err_count, 16'hFFFF);
                check("sat_unlock", 16'(s_locked), 16'h0);
                check("sat_unlock_pulse", 16'(s_err_pulse), 16'h1);
                pv = lfsr_next(pv);
                s_in_data = pv;
                @(negedge clk);
                check("sat_relock", 16'(s_locked), 16'h1);
                check("sat_relock_pulse", 16'(s_err_pulse), 16'h0);
                for (int k = 0; k < 2; k++) begin
                    ex = lfsr_next(pv);
                    s_in_data = bad_word(ex);
                    pv = ex;
                    @(negedge clk);
                    check($sformatf("sat_hold%0d", k), s_err_count, 16'hFFFF);
                end
                ex = lfsr_next(pv);
                s_in_data   = bad_word(ex);
                s_clear_cnt = 1'b1;
                @(negedge clk);
                check("sat_clear_count", s_err_count, 16'h0000);
                check("sat_clear_pulse", 16'(s_err_pulse), 16'h1);
                check("sat_clear_locked", 16'(s_locked), 16'h1);
                s_in_valid  = 1'b0;
                s_clear_cnt = 1'b0;
                @(negedge clk);
                check("sat_idle_pulse", 16'(s_err_pulse), 16'h0);
                check("sat_idle_count", s_err_count, 16'h0000);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
